cpu_alu_seq: RTL and testbench
==============================

CPU_ALU_SEQ -- requirements
Module: cpu_alu_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width; legal values are powers of two, 8..64.
REQ-002 Parameter SH, default $clog2(WIDTH): shift/rotate amount width; derived, not overridden.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  request present on A, B and op.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B; bits [SH-1:0] give the shift/rotate amount.
REQ-009 op  input  3  0 ADD, 1 SUB, 2 MUL, 3 SHL, 4 SHR (logical), 5 ROR, 6 PASSA, 7 PASSB.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  WIDTH  operation result.
REQ-013 OF, CF, ZF, NF  output  1 each  flag values.
REQ-014 OF_en, CF_en, ZF_en, NF_en  output  1 each  flag update enables.
REQ-015 busy  output  1  high in every state other than IDLE.

Function
REQ-016 FSM states and transitions:
- IDLE -> EXEC on accept when op≠MUL.
- IDLE -> MUL on accept when op=MUL.
- EXEC -> DONE after 1 cycle.
- MUL -> DONE after WIDTH cycles.
- DONE -> IDLE when out_ready=1.
REQ-017 in_ready = (state==IDLE); accept = in_valid & in_ready; A, B and op are captured into registers on accept.
REQ-018 Latency: out_valid rises 2 cycles after the accept edge for non-MUL ops and WIDTH+1 cycles after it for MUL.
REQ-019 Throughput: no new request is accepted before the DONE state exits.
REQ-020 out_valid = (state==DONE); result, flags and enables are registered and held stable while out_valid=1 and out_ready=0.
REQ-021 The result handshake completes on the edge where out_valid=1 and out_ready=1.
REQ-022 ADD and SUB results are modulo 2^WIDTH.
REQ-023 For ADD and SUB all four enables are 1.
REQ-024 ADD: CF = carry out of the MSB.
REQ-025 SUB: CF = borrow, i.e. 1 when A < B unsigned.
REQ-026 ADD and SUB: OF = two's-complement signed overflow.
REQ-027 MUL is unsigned shift-and-add, one multiplier bit per cycle; no combinational WIDTH×WIDTH multiplier is used.
REQ-028 MUL: result = low WIDTH bits of the 2*WIDTH-bit product.
REQ-029 MUL: CF = OF = 1 when the high WIDTH bits of the product are nonzero; all four enables are 1.
REQ-030 SHL and SHR shift by n = B[SH-1:0]; zeros fill the vacated bits; higher bits of B are ignored.
REQ-031 SHL with n>0: CF = A[WIDTH-n]. SHR with n>0: CF = A[n-1].
REQ-032 SHL and SHR: CF_en = (n≠0); ZF_en = NF_en = 1; OF_en = 0.
REQ-033 ROR rotates right by n = B[SH-1:0]; n=0 returns A unchanged.
REQ-034 ROR: ZF_en = NF_en = 1; CF_en = OF_en = 0.
REQ-035 PASSA returns A; PASSB returns B; all enables are 0.
REQ-036 For every op: ZF = (result==0) and NF = result[WIDTH-1]. When a flag's enable is 0, that flag reads 0.
REQ-037 Changes on in_valid, A, B or op while busy=1 have no effect.

Reset
REQ-038 While rst_n=0: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, result = 0, all flags and enables = 0.
REQ-039 Asserting rst_n low mid-operation (EXEC, MUL or DONE) abandons the operation; no out_valid is produced for it.
REQ-040 The first accept after reset release can occur on the first clock edge on which rst_n=1.

Verification (WIDTH=32)
REQ-041 ADD A=0xFFFFFFFF, B=1 -> result=0, CF=1, ZF=1, OF=0, NF=0, all enables=1, out_valid 2 cycles after accept.
REQ-042 SUB A=0x80000000, B=1 -> result=0x7FFFFFFF, OF=1, CF=0, NF=0, ZF=0.
REQ-043 MUL A=0x00010000, B=0x00010000 -> result=0, ZF=1, CF=OF=1, out_valid exactly 33 cycles after accept, in_ready=0 throughout.
REQ-044 ROR A=0x00000001 with B=1 and with B=33 -> result=0x80000000, NF=1, CF_en=0. SHR A=0x3, B=1 -> result=0x1, CF=1.
REQ-045 Backpressure: hold out_ready=0 for 5 cycles in DONE, toggling in_valid/A/B -> result and flags unchanged, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-046 Pull rst_n low 10 cycles into a MUL -> outputs immediately take the REQ-038 values; after release a PASSB B=0x5A returns 0x5A with all enables=0.

Source files
------------

// File: rtl/cpu_alu_seq_if.sv
// Request/response bundle for the sequential ALU: operand handshake in,
// result handshake out, plus the flag values and their update enables.
interface cpu_alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             OF;
    logic             CF;
    logic             ZF;
    logic             NF;
    logic             OF_en;
    logic             CF_en;
    logic             ZF_en;
    logic             NF_en;
    logic             busy;

    // Both sides use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both 1; the producer holds its payload until then.
    modport master (
        output in_valid, A, B, op, out_ready,
        input  in_ready, out_valid, result, OF, CF, ZF, NF,
        input  OF_en, CF_en, ZF_en, NF_en, busy
    );

    modport slave (
        input  in_valid, A, B, op, out_ready,
        output in_ready, out_valid, result, OF, CF, ZF, NF,
        output OF_en, CF_en, ZF_en, NF_en, busy
    );
endinterface

// File: rtl/cpu_alu_seq.sv
// One-request-at-a-time ALU: single-cycle ops go through EXEC, MUL runs a
// bit-serial shift-and-add for WIDTH cycles; results are held in DONE.
module cpu_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    cpu_alu_seq_if.slave bus,
    output logic [1:0]   state_o
);
    localparam int SH = $clog2(WIDTH);
    localparam logic [SH-1:0] CNT_LAST = SH'(WIDTH - 1);
    localparam logic [SH:0]   W_CNT    = (SH + 1)'(WIDTH);

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_MUL   = 3'd2;
    localparam logic [2:0] OP_SHL   = 3'd3;
    localparam logic [2:0] OP_SHR   = 3'd4;
    localparam logic [2:0] OP_ROR   = 3'd5;
    localparam logic [2:0] OP_PASSA = 3'd6;
    localparam logic [2:0] OP_PASSB = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
    logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
    logic [SH-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;   // {OF, CF, ZF, NF}
    logic [3:0]       en_q, en_d;         // {OF_en, CF_en, ZF_en, NF_en}

    logic             accept;
    logic             load_out;
    logic [SH-1:0]    amt;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w;
    logic [WIDTH-1:0] ror_r;
    logic [WIDTH-1:0] res_raw;
    logic             cf_raw, of_raw;

    assign accept   = bus.in_valid && (state_q == S_IDLE);
    assign load_out = (state_q == S_EXEC) ||
                      ((state_q == S_MUL) && (cnt_q == CNT_LAST));
    assign amt      = b_q[SH-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = (bus.op == OP_MUL) ? S_MUL : S_EXEC;
            S_EXEC:  state_d = S_DONE;
            S_MUL:   if (cnt_q == CNT_LAST) state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Product register {hi, lo}: lo starts as the multiplier and is consumed
    // LSB first while the partial product shifts in from the top.
    always_comb begin
        mul_sum   = {1'b0, prod_hi_q} + (prod_lo_q[0] ? {1'b0, a_q} : '0);
        prod_hi_d = prod_hi_q;
        prod_lo_d = prod_lo_q;
        cnt_d     = cnt_q;
        if (accept) begin
            prod_hi_d = '0;
            prod_lo_d = bus.B;
            cnt_d     = '0;
        end else if (state_q == S_MUL) begin
            prod_hi_d = mul_sum[WIDTH:1];
            prod_lo_d = {mul_sum[0], prod_lo_q[WIDTH-1:1]};
            cnt_d     = cnt_q + SH'(1);
        end
    end

    always_comb begin
        add_w   = {1'b0, a_q} + {1'b0, b_q};
        sub_w   = {1'b0, a_q} - {1'b0, b_q};
        shl_w   = {1'b0, a_q} << amt;           // bit WIDTH is the last bit shifted out
        shr_w   = {a_q, 1'b0} >> amt;           // bit 0 is the last bit shifted out
        ror_r   = (a_q >> amt) | (a_q << (W_CNT - {1'b0, amt}));
        res_raw = '0;
        cf_raw  = 1'b0;
        of_raw  = 1'b0;
        en_d    = 4'b0000;
        if (state_q == S_MUL) begin
            res_raw = prod_lo_d;
            cf_raw  = |prod_hi_d;
            of_raw  = |prod_hi_d;
            en_d    = 4'b1111;
        end else begin
            case (op_q)
                OP_ADD: begin
                    res_raw = add_w[WIDTH-1:0];
                    cf_raw  = add_w[WIDTH];
                    of_raw  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (add_w[WIDTH-1] != a_q[WIDTH-1]);
                    en_d    = 4'b1111;
                end
                OP_SUB: begin
                    res_raw = sub_w[WIDTH-1:0];
                    cf_raw  = sub_w[WIDTH];
                    of_raw  = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (sub_w[WIDTH-1] != a_q[WIDTH-1]);
                    en_d    = 4'b1111;
                end
                OP_SHL: begin
                    res_raw = shl_w[WIDTH-1:0];
                    cf_raw  = shl_w[WIDTH];
                    en_d    = {1'b0, (amt != '0), 2'b11};
                end
                OP_SHR: begin
                    res_raw = shr_w[WIDTH:1];
                    cf_raw  = shr_w[0];
                    en_d    = {1'b0, (amt != '0), 2'b11};
                end
                OP_ROR: begin
                    res_raw = ror_r;
                    en_d    = 4'b0011;
                end
                OP_PASSA: res_raw = a_q;
                OP_PASSB: res_raw = b_q;
                default:  res_raw = '0;
            endcase
        end
        result_d = res_raw;
        flags_d  = {of_raw & en_d[3],
                    cf_raw & en_d[2],
                    (res_raw == '0) & en_d[1],
                    res_raw[WIDTH-1] & en_d[0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            en_q      <= '0;
        end else begin
            prod_hi_q <= prod_hi_d;
            prod_lo_q <= prod_lo_d;
            cnt_q     <= cnt_d;
            if (accept) begin
                a_q  <= bus.A;
                b_q  <= bus.B;
                op_q <= bus.op;
            end
            if (load_out) begin
                result_q <= result_d;
                flags_q  <= flags_d;
                en_q     <= en_d;
            end
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.result    = result_q;
    assign bus.OF        = flags_q[3];
    assign bus.CF        = flags_q[2];
    assign bus.ZF        = flags_q[1];
    assign bus.NF        = flags_q[0];
    assign bus.OF_en     = en_q[3];
    assign bus.CF_en     = en_q[2];
    assign bus.ZF_en     = en_q[1];
    assign bus.NF_en     = en_q[0];
    assign state_o       = state_q;
endmodule

// File: tb/tb_cpu_alu_seq.sv
// Bench for cpu_alu_seq at WIDTH=32: directed corner cases plus random ops
// scored against an arithmetic reference model.
module tb_cpu_alu_seq;
    localparam int W  = 32;
    localparam int EW = W + 8;   // {result, OF,CF,ZF,NF, OF_en,CF_en,ZF_en,NF_en}

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_MUL   = 3'd2;
    localparam logic [2:0] OP_SHL   = 3'd3;
    localparam logic [2:0] OP_SHR   = 3'd4;
    localparam logic [2:0] OP_ROR   = 3'd5;
    localparam logic [2:0] OP_PASSA = 3'd6;
    localparam logic [2:0] OP_PASSB = 3'd7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    state_dbg;
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [EW-1:0] exp_q[$];
    logic [W-1:0]  last_res;
    logic [3:0]    last_flags;
    logic [3:0]    last_en;
    int            last_lat;

    cpu_alu_seq_if #(.WIDTH(W)) bus ();

    cpu_alu_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [EW-1:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0]  r;
        logic          of, cf, zf, nf;
        logic [3:0]    en;
        logic [63:0]   p;
        longint        sa, sb, s;
        longint        mx;
        int            n;
        n  = int'(b[4:0]);
        sa = $signed(a);
        sb = $signed(b);
        mx = 64'sh7FFF_FFFF;
        r  = '0; of = 1'b0; cf = 1'b0; en = 4'b0000;
        case (o)
            OP_ADD: begin
                p  = 64'(a) + 64'(b);
                r  = p[31:0];
                cf = p[32];
                s  = sa + sb;
                of = (s > mx) || (s < -mx - 1);
                en = 4'b1111;
            end
            OP_SUB: begin
                r  = a - b;
                cf = (a < b);
                s  = sa - sb;
                of = (s > mx) || (s < -mx - 1);
                en = 4'b1111;
            end
            OP_MUL: begin
                p  = 64'(a) * 64'(b);
                r  = p[31:0];
                cf = (p[63:32] != 0);
                of = cf;
                en = 4'b1111;
            end
            OP_SHL: begin
                r  = a << n;
                cf = (n != 0) ? a[W-n] : 1'b0;
                en = {1'b0, (n != 0), 2'b11};
            end
            OP_SHR: begin
                r  = a >> n;
                cf = (n != 0) ? a[n-1] : 1'b0;
                en = {1'b0, (n != 0), 2'b11};
            end
            OP_ROR: begin
                r = a;
                for (int i = 0; i < n; i++) r = {r[0], r[W-1:1]};
                en = 4'b0011;
            end
            OP_PASSA: r = a;
            default:  r = b;
        endcase
        zf = (r == 0) & en[1];
        nf = r[W-1] & en[0];
        return {r, of & en[3], cf & en[2], zf, nf, en};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic jitter();
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.A        = $urandom;
        bus.B        = $urandom;
        bus.op       = 3'($urandom_range(0, 7));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},  64'(bus.in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_busy"},      64'(bus.busy), 64'd0);
        check({tag, "_result"},    64'(bus.result), 64'd0);
        check({tag, "_flags"},     64'({bus.OF, bus.CF, bus.ZF, bus.NF}), 64'd0);
        check({tag, "_en"},        64'({bus.OF_en, bus.CF_en, bus.ZF_en, bus.NF_en}), 64'd0);
    endtask

    task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit wait_done);
        int guard;
        int lat;
        bit saw_idle;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.A        = a;
        bus.B        = b;
        guard = 0;
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        exp_q.push_back(model(o, a, b));
        #1;
        if (!wait_done) begin
            bus.in_valid = 1'b0;
            return;
        end
        lat      = 1;
        saw_idle = 1'b0;
        while (!bus.out_valid && lat < 200) begin
            if (bus.in_ready || !bus.busy) saw_idle = 1'b1;
            jitter();
            @(posedge clk);
            #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        last_lat = lat;
        check("latency", 64'(lat), (o == OP_MUL) ? 64'(W + 1) : 64'd2);
        check("busy_not_ready", 64'(saw_idle), 64'd0);
    endtask

    task automatic collect(input int bp);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        bus.out_ready = 1'b0;
        for (int i = 0; i < bp; i++) begin
            jitter();
            @(posedge clk);
            #1;
            check("hold_out_valid", 64'(bus.out_valid), 64'd1);
            check("hold_in_ready",  64'(bus.in_ready), 64'd0);
            check("hold_result",    64'(bus.result), 64'(e[EW-1:8]));
            check("hold_flags",     64'({bus.OF, bus.CF, bus.ZF, bus.NF}), 64'(e[7:4]));
        end
        bus.in_valid = 1'b0;
        last_res   = bus.result;
        last_flags = {bus.OF, bus.CF, bus.ZF, bus.NF};
        last_en    = {bus.OF_en, bus.CF_en, bus.ZF_en, bus.NF_en};
        check("out_valid", 64'(bus.out_valid), 64'd1);
        check("result",    64'(last_res), 64'(e[EW-1:8]));
        check("flags",     64'(last_flags), 64'(e[7:4]));
        check("enables",   64'(last_en), 64'(e[3:0]));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("post_in_ready",  64'(bus.in_ready), 64'd1);
        check("post_out_valid", 64'(bus.out_valid), 64'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.op        = '0;
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;

        // carry out of MSB, accepted on the first edge after release
        send(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1);
        collect(0);
        check("add_result", 64'(last_res), 64'd0);
        check("add_flags", 64'(last_flags), 64'b0110);
        check("add_en", 64'(last_en), 64'hF);

        send(OP_SUB, 32'h8000_0000, 32'h1, 1'b1);
        collect(0);
        check("sub_result", 64'(last_res), 64'h7FFF_FFFF);
        check("sub_flags", 64'(last_flags), 64'b1000);

        send(OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b1);
        collect(0);
        check("mul_result", 64'(last_res), 64'd0);
        check("mul_flags", 64'(last_flags), 64'b1110);
        check("mul_latency", 64'(last_lat), 64'd33);

        send(OP_ROR, 32'h1, 32'd1, 1'b1);
        collect(0);
        check("ror1_result", 64'(last_res), 64'h8000_0000);
        check("ror1_flags", 64'(last_flags), 64'b0001);
        check("ror1_en", 64'(last_en), 64'b0011);

        send(OP_ROR, 32'h1, 32'd33, 1'b1);
        collect(0);
        check("ror33_result", 64'(last_res), 64'h8000_0000);

        send(OP_SHR, 32'h3, 32'd1, 1'b1);
        collect(0);
        check("shr_result", 64'(last_res), 64'h1);
        check("shr_cf", 64'(last_flags[2]), 64'd1);

        // backpressure in DONE with noisy inputs
        send(OP_ADD, $urandom, $urandom, 1'b1);
        collect(5);

        // reset mid-multiply abandons the operation
        send(OP_MUL, $urandom, $urandom, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("mid_reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_reset("mid_reset_hold");
        rst_n = 1'b1;
        send(OP_PASSB, $urandom, 32'h5A, 1'b1);
        collect(0);
        check("passb_result", 64'(last_res), 64'h5A);
        check("passb_en", 64'(last_en), 64'd0);

        for (int k = 0; k < 60; k++) begin
            send(3'($urandom_range(0, 7)), pick(), pick(), 1'b1);
            collect($urandom_range(0, 3));
        end

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
